// File: rtl/uart_rx_os16_if.sv
// Receive-data handshake between the UART receiver and its consumer.
// The master side owns the holding register; the slave side accepts bytes.
interface uart_rx_os16_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_os16.sv
// 16x-oversampling UART receiver with 3-sample majority vote,
// optional parity and a single-entry valid/ready holding register.
module uart_rx_os16 #(
  parameter int unsigned OS_DIV = 1,
  parameter int unsigned PARITY = 0
) (
  input  logic rxclk,
  input  logic reset,
  input  logic rx_in,
  input  logic rx_enable,
  output logic busy,
  output logic frame_err,
  output logic parity_err,
  output logic overrun,
  uart_rx_os16_if.master rx
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } state_t;

  localparam logic [15:0] DIV_TC = 16'(OS_DIV - 1);
  localparam logic        ODD    = (PARITY == 2);

  state_t      state;
  logic        sync1;
  logic        sync2;
  logic        prev;
  logic [15:0] div;
  logic [3:0]  tcnt;
  logic [2:0]  idx;
  logic [1:0]  smp;
  logic [7:0]  shreg;
  logic        perr;

  logic        start_edge;
  logic        tick;
  logic [3:0]  tcnt_nx;
  logic        dec_tick;
  logic        decision;

  assign start_edge = prev & ~sync2;
  assign tick       = (div == DIV_TC);
  assign tcnt_nx    = tcnt + 4'd1;
  assign dec_tick   = tick && (tcnt_nx == 4'd9);
  // Third vote is the live sample on the deciding tick.
  assign decision   = (smp[0] & smp[1])
                    | (smp[0] & sync2)
                    | (smp[1] & sync2);

  always_ff @(posedge rxclk) begin
    if (!reset) begin
      sync1       <= 1'b1;
      sync2       <= 1'b1;
      prev        <= 1'b1;
      div         <= '0;
      tcnt        <= '0;
      idx         <= '0;
      smp         <= '0;
      shreg       <= '0;
      perr        <= 1'b0;
      state       <= IDLE;
      busy        <= 1'b0;
      frame_err   <= 1'b0;
      parity_err  <= 1'b0;
      overrun     <= 1'b0;
      rx.rx_data  <= '0;
      rx.rx_valid <= 1'b0;
    end else begin
      sync1      <= rx_in;
      sync2      <= sync1;
      prev       <= sync2;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
      if (rx.rx_valid && rx.rx_ready)
        rx.rx_valid <= 1'b0;
      div <= tick ? 16'd0 : div + 16'd1;
      if (tick) begin
        tcnt <= tcnt_nx;
        if (tcnt_nx == 4'd7) smp[0] <= sync2;
        if (tcnt_nx == 4'd8) smp[1] <= sync2;
      end
      if (state != IDLE && !rx_enable) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (rx_enable && start_edge) begin
              state <= START;
              busy  <= 1'b1;
              div   <= '0;
              tcnt  <= '0;
              idx   <= '0;
              perr  <= 1'b0;
            end
          end
          START: begin
            if (dec_tick) begin
              if (decision) begin
                state <= IDLE;
                busy  <= 1'b0;
              end else begin
                state <= DATA;
              end
            end
          end
          DATA: begin
            if (dec_tick) begin
              shreg <= {decision, shreg[7:1]};
              idx   <= idx + 3'd1;
              if (idx == 3'd7)
                state <= (PARITY != 0) ? PAR : STOP;
            end
          end
          PAR: begin
            if (dec_tick) begin
              perr  <= (decision != (^shreg ^ ODD));
              state <= STOP;
            end
          end
          STOP: begin
            if (dec_tick) begin
              state <= IDLE;
              busy  <= 1'b0;
              if (!decision)
                frame_err <= 1'b1;
              else if (perr)
                parity_err <= 1'b1;
              else if (rx.rx_valid && !rx.rx_ready)
                overrun <= 1'b1;
              else begin
                rx.rx_data  <= shreg;
                rx.rx_valid <= 1'b1;
              end
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_os16.sv
// Directed bench for uart_rx_os16: one receiver without parity,
// one with even parity, both at OS_DIV=1.
module tb_uart_rx_os16;

  logic rxclk = 1'b0;
  logic reset;
  logic rx0;
  logic rx1;
  logic en;
  logic busy0, fe0, pe0, ov0;
  logic busy1, fe1, pe1, ov1;
  logic act0 = 1'b0;
  logic act1 = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int t0 = 0;
  int nfe0 = 0, npe0 = 0, nov0 = 0, nv0 = 0;
  int nfe1 = 0, npe1 = 0, nov1 = 0, nv1 = 0;
  logic vq0 = 1'b0;
  logic vq1 = 1'b0;
  int s_fe, s_pe, s_ov, s_v;

  uart_rx_os16_if i0 ();
  uart_rx_os16_if i1 ();

  uart_rx_os16 #(.OS_DIV(1), .PARITY(0)) u0 (
    .rxclk     (rxclk),
    .reset     (reset),
    .rx_in     (rx0),
    .rx_enable (en),
    .busy      (busy0),
    .frame_err (fe0),
    .parity_err(pe0),
    .overrun   (ov0),
    .rx        (i0)
  );

  uart_rx_os16 #(.OS_DIV(1), .PARITY(1)) u1 (
    .rxclk     (rxclk),
    .reset     (reset),
    .rx_in     (rx1),
    .rx_enable (en),
    .busy      (busy1),
    .frame_err (fe1),
    .parity_err(pe1),
    .overrun   (ov1),
    .rx        (i1)
  );

  always #5 rxclk = ~rxclk;

  always @(posedge rxclk) cyc <= cyc + 1;

  always @(negedge rxclk) begin
    if (fe0) nfe0++;
    if (pe0) npe0++;
    if (ov0) nov0++;
    if (i0.rx_valid && !vq0) nv0++;
    vq0 = i0.rx_valid;
    if (fe1) nfe1++;
    if (pe1) npe1++;
    if (ov1) nov1++;
    if (i1.rx_valid && !vq1) nv1++;
    vq1 = i1.rx_valid;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic at(input int k);
    do @(negedge rxclk); while (cyc < t0 + k);
  endtask

  task automatic tx(input int ln, input logic [7:0] b, input bit pen,
                    input logic pb, input logic sb);
    logic [10:0] f;
    int n;
    if (pen) begin
      f = {sb, pb, b, 1'b0};
      n = 11;
    end else begin
      f = {1'b1, sb, b, 1'b0};
      n = 10;
    end
    if (ln == 0) act0 = 1'b1; else act1 = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (ln == 0) rx0 = f[i]; else rx1 = f[i];
      repeat (16) @(posedge rxclk);
      #1;
    end
    if (ln == 0) begin rx0 = 1'b1; act0 = 1'b0; end
    else begin rx1 = 1'b1; act1 = 1'b0; end
  endtask

  task automatic wait_tx();
    int k;
    k = 0;
    while ((act0 || act1) && k < 1000) begin
      @(posedge rxclk);
      k++;
    end
    chk("tx_done", {31'd0, act0 | act1}, 32'd0);
    repeat (4) @(posedge rxclk);
    #1;
  endtask

  task automatic snap();
    s_fe = nfe0;
    s_pe = npe0;
    s_ov = nov0;
    s_v  = nv0;
  endtask

  initial begin
    reset = 1'b0;
    rx0 = 1'b1;
    rx1 = 1'b1;
    en = 1'b1;
    i0.rx_ready = 1'b1;
    i1.rx_ready = 1'b1;
    repeat (3) @(posedge rxclk);
    @(negedge rxclk);
    chk("rst_data", i0.rx_data, 32'h0);
    chk("rst_valid", i0.rx_valid, 32'd0);
    chk("rst_busy", busy0, 32'd0);
    chk("rst_ferr", fe0, 32'd0);
    chk("rst_perr", pe0, 32'd0);
    chk("rst_ovr", ov0, 32'd0);
    chk("rst_busy1", busy1, 32'd0);
    chk("rst_valid1", i1.rx_valid, 32'd0);
    reset = 1'b1;
    repeat (20) @(posedge rxclk);
    #1;

    // 0xA5, latency and handshake
    snap();
    t0 = cyc;
    fork tx(0, 8'hA5, 1'b0, 1'b0, 1'b1); join_none
    at(2);
    chk("a5_busy_e2", busy0, 32'd0);
    at(3);
    chk("a5_busy_e3", busy0, 32'd1);
    at(155);
    chk("a5_valid_e155", i0.rx_valid, 32'd0);
    chk("a5_busy_e155", busy0, 32'd1);
    at(156);
    chk("a5_valid_e156", i0.rx_valid, 32'd1);
    chk("a5_data", i0.rx_data, 32'hA5);
    chk("a5_busy_e156", busy0, 32'd0);
    at(157);
    chk("a5_valid_e157", i0.rx_valid, 32'd0);
    wait_tx();
    chk("a5_nferr", nfe0 - s_fe, 32'd0);
    chk("a5_nperr", npe0 - s_pe, 32'd0);
    chk("a5_novr", nov0 - s_ov, 32'd0);
    chk("a5_nvalid", nv0 - s_v, 32'd1);

    // 0x3C then 0xC3 back-to-back, consumer stalled
    snap();
    i0.rx_ready = 1'b0;
    t0 = cyc;
    fork
      begin
        tx(0, 8'h3C, 1'b0, 1'b0, 1'b1);
        tx(0, 8'hC3, 1'b0, 1'b0, 1'b1);
      end
    join_none
    at(156);
    chk("b2b_valid1", i0.rx_valid, 32'd1);
    chk("b2b_data1", i0.rx_data, 32'h3C);
    at(157);
    chk("b2b_hold", i0.rx_valid, 32'd1);
    at(316);
    chk("b2b_ovr", ov0, 32'd1);
    chk("b2b_keep", i0.rx_data, 32'h3C);
    chk("b2b_valid2", i0.rx_valid, 32'd1);
    at(317);
    chk("b2b_ovr_end", ov0, 32'd0);
    wait_tx();
    i0.rx_ready = 1'b1;
    @(negedge rxclk);
    chk("b2b_pre_acc", i0.rx_valid, 32'd1);
    @(negedge rxclk);
    chk("b2b_post_acc", i0.rx_valid, 32'd0);
    chk("b2b_novr", nov0 - s_ov, 32'd1);
    chk("b2b_nvalid", nv0 - s_v, 32'd1);

    // 4-cycle glitch is rejected as a false start
    snap();
    @(posedge rxclk);
    #1;
    t0 = cyc;
    rx0 = 1'b0;
    at(3);
    chk("gl_busy_e3", busy0, 32'd1);
    @(posedge rxclk);
    #1;
    rx0 = 1'b1;
    at(11);
    chk("gl_busy_e11", busy0, 32'd1);
    at(12);
    chk("gl_busy_e12", busy0, 32'd0);
    repeat (200) @(posedge rxclk);
    #1;
    chk("gl_nvalid", nv0 - s_v, 32'd0);
    chk("gl_nflags", (nfe0 - s_fe) + (npe0 - s_pe) + (nov0 - s_ov), 32'd0);

    // 0x55 with stop bit low, then 0x12
    snap();
    t0 = cyc;
    fork tx(0, 8'h55, 1'b0, 1'b0, 1'b0); join_none
    at(156);
    chk("fe_pulse", fe0, 32'd1);
    chk("fe_valid", i0.rx_valid, 32'd0);
    at(157);
    chk("fe_pulse_end", fe0, 32'd0);
    wait_tx();
    t0 = cyc;
    fork tx(0, 8'h12, 1'b0, 1'b0, 1'b1); join_none
    at(156);
    chk("fe_next_valid", i0.rx_valid, 32'd1);
    chk("fe_next_data", i0.rx_data, 32'h12);
    wait_tx();
    chk("fe_nferr", nfe0 - s_fe, 32'd1);
    chk("fe_nvalid", nv0 - s_v, 32'd1);

    // even parity on 0x07: bad parity bit, then good
    t0 = cyc;
    fork tx(1, 8'h07, 1'b1, 1'b0, 1'b1); join_none
    at(172);
    chk("par_err", pe1, 32'd1);
    chk("par_err_valid", i1.rx_valid, 32'd0);
    at(173);
    chk("par_err_end", pe1, 32'd0);
    wait_tx();
    t0 = cyc;
    fork tx(1, 8'h07, 1'b1, 1'b1, 1'b1); join_none
    at(171);
    chk("par_ok_e171", i1.rx_valid, 32'd0);
    at(172);
    chk("par_ok_valid", i1.rx_valid, 32'd1);
    chk("par_ok_data", i1.rx_data, 32'h07);
    chk("par_ok_perr", pe1, 32'd0);
    wait_tx();
    chk("par_npe", npe1, 32'd1);
    chk("par_nv", nv1, 32'd1);
    chk("par_other", nfe1 + nov1, 32'd0);

    // reset pulse in the middle of 0xFF, then 0x81
    snap();
    t0 = cyc;
    fork tx(0, 8'hFF, 1'b0, 1'b0, 1'b1); join_none
    at(50);
    chk("rs_busy_pre", busy0, 32'd1);
    reset = 1'b0;
    @(posedge rxclk);
    #1;
    reset = 1'b1;
    @(negedge rxclk);
    chk("rs_busy_post", busy0, 32'd0);
    chk("rs_data_clr", i0.rx_data, 32'h0);
    wait_tx();
    chk("rs_nvalid", nv0 - s_v, 32'd0);
    t0 = cyc;
    fork tx(0, 8'h81, 1'b0, 1'b0, 1'b1); join_none
    at(156);
    chk("rs_next_valid", i0.rx_valid, 32'd1);
    chk("rs_next_data", i0.rx_data, 32'h81);
    wait_tx();

    // receiver disabled mid-frame
    snap();
    t0 = cyc;
    fork tx(0, 8'h5A, 1'b0, 1'b0, 1'b1); join_none
    at(60);
    chk("en_busy_pre", busy0, 32'd1);
    en = 1'b0;
    at(61);
    chk("en_busy_post", busy0, 32'd0);
    wait_tx();
    en = 1'b1;
    repeat (20) @(posedge rxclk);
    #1;
    chk("en_nvalid", nv0 - s_v, 32'd0);
    chk("en_nflags", (nfe0 - s_fe) + (npe0 - s_pe) + (nov0 - s_ov), 32'd0);
    chk("en_hold_data", i0.rx_data, 32'h81);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
